// File: rtl/clk_gen_pkg.sv
// Shared types and reset constants for the clk_gen programmable clock generator.
package clk_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PHASE,
    RUN_HI,
    RUN_LO,
    STOP
  } state_e;

  localparam int unsigned RST_DIV   = 1;
  localparam int unsigned RST_HI    = 1;
  localparam int unsigned RST_PHASE = 0;

endpackage

// File: rtl/clk_gen_cnt.sv
// Loadable down-counter with terminal-count flag; shared by phase, high and low intervals.
module clk_gen_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter parks at zero so it never wraps past the loaded range.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/clk_gen.sv
// Programmable clock generator with phase delay, shadowed configuration and lock flag.
// Define CLK_GEN_DUTY_EN to add the hi_val port for independent high-phase length.
module clk_gen
  import clk_gen_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] div_val,
  input  logic [CNT_W-1:0] phase_val,
`ifdef CLK_GEN_DUTY_EN
  input  logic [CNT_W-1:0] hi_val,
`endif
  output logic             cfg_ack,
  output logic             gclk,
  output logic             period_tick,
  output logic             locked
);

  state_e state_q, state_d;
  logic gclk_q, gclk_d, tick_q, tick_d, locked_q, locked_d, ack_q;
  logic pending_q, pending_d;
  logic [CNT_W-1:0] shadowDiv_q, shadowPhase_q, activeDiv_q, activePhase_q;
  logic [CNT_W-1:0] shadowHi, activeHi, clampDiv, clampHi, useHi, usePhase;
  logic apply, boundary, cntLoad, cntTc;
  logic [CNT_W-1:0] cntVal;

  // A period boundary is the only point in RUN where a pending configuration may take effect.
  assign boundary  = (state_q == RUN_LO) && en && cntTc;
  assign apply     = (state_q == IDLE) || (boundary && pending_q);
  assign pending_d = cfg_load | (pending_q & ~apply);
  assign clampDiv  = (shadowDiv_q == '0) ? CNT_W'(1) : shadowDiv_q;
  assign clampHi   = (shadowHi == '0) ? CNT_W'(1) : shadowHi;
  assign useHi     = apply ? clampHi : activeHi;
  assign usePhase  = apply ? shadowPhase_q : activePhase_q;

  always_ff @(posedge mclk) begin
    if (rst) begin
      shadowDiv_q   <= CNT_W'(RST_DIV);
      shadowPhase_q <= CNT_W'(RST_PHASE);
      activeDiv_q   <= CNT_W'(RST_DIV);
      activePhase_q <= CNT_W'(RST_PHASE);
      pending_q     <= 1'b0;
    end else begin
      if (cfg_load) begin
        shadowDiv_q   <= div_val;
        shadowPhase_q <= phase_val;
      end
      if (apply) begin
        activeDiv_q   <= clampDiv;
        activePhase_q <= shadowPhase_q;
      end
      pending_q <= pending_d;
    end
  end

`ifdef CLK_GEN_DUTY_EN
  logic [CNT_W-1:0] shadowHi_q, activeHi_q;

  always_ff @(posedge mclk) begin
    if (rst) begin
      shadowHi_q <= CNT_W'(RST_HI);
      activeHi_q <= CNT_W'(RST_HI);
    end else begin
      if (cfg_load) begin
        shadowHi_q <= hi_val;
      end
      if (apply) begin
        activeHi_q <= clampHi;
      end
    end
  end

  assign shadowHi = shadowHi_q;
  assign activeHi = activeHi_q;
`else
  assign shadowHi = shadowDiv_q;
  assign activeHi = activeDiv_q;
`endif

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // STOP reuses the running count; gclk_q tells whether it is still in the high half.
  always_comb begin
    state_d = state_q;
    cntLoad = 1'b0;
    cntVal  = '0;
    case (state_q)
      IDLE: begin
        if (en) begin
          cntLoad = 1'b1;
          if (usePhase != '0) begin
            state_d = PHASE;
            cntVal  = usePhase - 1'b1;
          end else begin
            state_d = RUN_HI;
            cntVal  = useHi - 1'b1;
          end
        end
      end
      PHASE: begin
        if (!en) begin
          state_d = IDLE;
        end else if (cntTc) begin
          state_d = RUN_HI;
          cntLoad = 1'b1;
          cntVal  = useHi - 1'b1;
        end
      end
      RUN_HI: begin
        if (cntTc) begin
          state_d = en ? RUN_LO : STOP;
          cntLoad = 1'b1;
          cntVal  = activeDiv_q - 1'b1;
        end else if (!en) begin
          state_d = STOP;
        end
      end
      RUN_LO: begin
        if (cntTc) begin
          if (en) begin
            state_d = RUN_HI;
            cntLoad = 1'b1;
            cntVal  = useHi - 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (!en) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (cntTc) begin
          if (gclk_q) begin
            cntLoad = 1'b1;
            cntVal  = activeDiv_q - 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gclk_d   = 1'b0;
    tick_d   = 1'b0;
    locked_d = locked_q;
    case (state_d)
      RUN_HI: begin
        gclk_d = 1'b1;
        tick_d = (state_q != RUN_HI);
        if (boundary) begin
          locked_d = ~pending_q;
        end
      end
      RUN_LO: begin
        gclk_d = 1'b0;
      end
      STOP: begin
        gclk_d   = gclk_q & ~cntTc;
        locked_d = 1'b0;
      end
      default: begin
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      gclk_q   <= 1'b0;
      tick_q   <= 1'b0;
      locked_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      gclk_q   <= gclk_d;
      tick_q   <= tick_d;
      locked_q <= locked_d;
      ack_q    <= cfg_load;
    end
  end

  clk_gen_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i     (mclk),
    .rst_i     (rst),
    .load_i    (cntLoad),
    .load_val_i(cntVal),
    .tc_o      (cntTc)
  );

  assign gclk        = gclk_q;
  assign period_tick = tick_q;
  assign locked      = locked_q;
  assign cfg_ack     = ack_q;

endmodule

// File: doc/clk_gen.md
CLK_GEN -- requirements
Module: clk_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the divider, phase and duty counters.
REQ-002 SHALL have port mclk  input  1  master clock; all logic SHALL run on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port en  input  1  level request to run the generated clock.
REQ-005 SHALL have port cfg_load  input  1  one-cycle strobe to capture the configuration inputs.
REQ-006 SHALL have port div_val  input  CNT_W  low-phase length in mclk cycles; also the high-phase length when duty control is compiled out.
REQ-007 SHALL have port phase_val  input  CNT_W  mclk cycles of delay from start to the first gclk rise.
REQ-008 SHALL have port cfg_ack  output  1  one-cycle pulse, registered, in the cycle after cfg_load.
REQ-009 SHALL have port gclk  output  1  generated clock, driven directly from a flop.
REQ-010 SHALL have port period_tick  output  1  one-cycle pulse in the first mclk cycle in which gclk is high.
REQ-011 SHALL have port locked  output  1  high once a full period has completed with the current configuration.

Function
REQ-012 SHALL implement states IDLE, PHASE, RUN_HI, RUN_LO and STOP.
REQ-013 SHALL keep active config registers and a shadow register set; cfg_load SHALL write the shadow every cycle it is high, in any state.
REQ-014 SHALL copy shadow to active immediately while in IDLE, and in RUN only at the RUN_LO->RUN_HI boundary.
REQ-015 SHALL clamp a div_val or hi_val of 0 to 1 when it is copied to the active set.
REQ-016 SHALL go from IDLE with en=1 to PHASE when phase_val>0, or else directly to RUN_HI.
REQ-017 SHALL stay in PHASE for exactly phase_val mclk cycles and then enter RUN_HI.
REQ-018 SHALL hold gclk=1 in RUN_HI for hi length cycles, then hold gclk=0 in RUN_LO for div length cycles, then repeat.
REQ-019 SHALL use period = hi + div mclk cycles; without the duty feature this is 2*div.
REQ-020 SHALL assert period_tick on every RUN_HI entry.
REQ-021 SHALL assert locked at the first RUN_LO->RUN_HI boundary that does not apply a new configuration.
REQ-022 SHALL clear locked when a new configuration is applied, and in the PHASE, STOP and IDLE states.
REQ-023 SHALL respond to en falling in RUN_HI or RUN_LO by entering STOP, which completes the current period (no gclk high shortened), and then enter IDLE with gclk=0.
REQ-024 SHALL respond to en falling in PHASE by returning to IDLE on the next edge, with gclk still 0.
REQ-025 SHALL, when en rises again during STOP, still complete the STOP period, pass through IDLE and restart through PHASE.
REQ-026 SHALL handle cfg_load in the same cycle as a boundary as follows: the boundary applies the old shadow, and the new shadow applies at the following boundary.
REQ-027 SHALL wrap all counters only within 0..value-1, with no overflow at value 2^CNT_W-1.

Reset
REQ-028 SHALL, when rst=1, force state IDLE and gclk=0, period_tick=0, locked=0, cfg_ack=0 on the next mclk edge.
REQ-029 SHALL set active and shadow div=1, hi=1, phase=0 on reset.
REQ-030 SHALL let a reset mid-period truncate gclk immediately, without waiting for the period to complete.

Configuration
REQ-031 SHALL, with macro CLK_GEN_DUTY_EN defined, add port hi_val  input  CNT_W  high-phase length, captured and applied like div_val.
REQ-032 SHALL, without CLK_GEN_DUTY_EN, have no hi_val port and use hi = div (50% duty).

Structure
REQ-033 SHALL place the state enum and the reset constants (div=1, hi=1, phase=0) in shared package clk_gen_pkg.
REQ-034 SHALL use one sub-module, clk_gen_cnt: a loadable down-counter with a terminal-count flag, reused for the phase, high and low phases.

Verification
REQ-035 SHALL cover: div=2, phase=0, en=1 -> gclk 1,1,0,0 repeating; period_tick every 4 cycles; locked high after the 1st period.
REQ-036 SHALL cover: phase=3, div=1 -> first gclk rise 3 cycles after entering PHASE; then period 2.
REQ-037 SHALL cover: in RUN with div=2, cfg_load div=5 mid-RUN_HI -> cfg_ack the next cycle; current period stays 4; next period 10; locked drops, then rises after a 10-cycle period.
REQ-038 SHALL cover: en=0 one cycle into RUN_HI with div=3 -> 3 high plus 3 low cycles complete, then IDLE with gclk=0.
REQ-039 SHALL cover: rst=1 while gclk=1 -> gclk=0 and locked=0 on the next edge; div_val=0 loaded -> behaves as div=1.
REQ-040 SHALL cover: with CLK_GEN_DUTY_EN, hi=1 and div=3 -> gclk 1,0,0,0 repeating; period_tick every 4 cycles.
